spi_word_master: RTL and testbench
==================================

# spi_word_master

SPI master that moves one 16-bit word per transaction between the boot/mailbox register bank and an external SPI device. It sits directly downstream of the boot ROM mailbox: the command word written into the mailbox's high transmit slot is handed here with a start strobe, and the received word is returned for write-back into the mailbox's receive slot. The interface is a single-word start/busy/valid handshake; the SPI side runs mode 0 (CPOL=0, CPHA=0), MSB first, with a programmable clock divider.

## Interface
- CLK_DIV, 2, SCLK half-period in clkEth cycles; legal range 1..255.
- clkEth  input  1  block clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request strobe; sampled on each clkEth edge, accepted only when busy=0.
- tx_data  input  16  word to transmit; captured on the accepting edge only.
- busy  output  1  high while a transaction is in progress.
- rx_data  output  16  last completed received word; holds until the next completion.
- rx_valid  output  1  one-cycle pulse marking a new rx_data.
- sclk  output  1  SPI clock, idle low.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in.
- ss_n  output  1  SPI slave select, active low.

## Operation
- Reset values: busy=0, rx_data=16'h0000, rx_valid=0, sclk=0, mosi=0, ss_n=1. The FSM goes to IDLE, and the divider and bit counters clear.
- FSM states:
  - IDLE: start=1 loads tx_data into the shift register, then goes to SHIFT_LO.
  - SHIFT_LO: sclk=0. When the divider expires, go to SHIFT_HI.
  - SHIFT_HI: sclk=1. When the divider expires, go to SHIFT_LO, or to DONE after bit 15.
  - DONE: lasts one cycle, then goes to IDLE.
- Divider: counts 0..CLK_DIV-1 and reloads to 0 on each sclk phase change.
- Bit counter: 4 bits, increments on each falling sclk transition, and wraps to 0 at completion.
- Shift register, 16 bits:
  - mosi always drives bit 15.
  - On the sclk rising transition, miso is captured into a separate sampled-bit flop.
  - On the falling transition, the register shifts left with the sampled bit entering bit 0.
  - After 16 falling transitions the register holds the received word, MSB first.
- Completion: rx_data is loaded from the shift register and rx_valid pulses. ss_n returns high, sclk stays low, and mosi returns to 0.
- start while busy=1 is ignored: no queueing and no effect on the current transfer.
- tx_data changes after the accepting edge have no effect.
- A reset asserted mid-transfer aborts immediately to the reset values. No rx_valid is produced and there is no partial rx_data update.

## Timing
- Edge 0 is the edge that samples start=1 with busy=0. After edge 0: busy=1, ss_n=0, sclk=0, mosi=tx_data[15].
- Half-period length is D=CLK_DIV.
- For bit n (n=0..15):
  - sclk rises after edge (2n+1)·D; miso is sampled at that edge.
  - sclk falls after edge (2n+2)·D; after that edge mosi=tx_data[14-n] (for n<15).
- After edge 32·D: sclk=0, ss_n=1, busy=0, rx_valid=1, rx_data holds the received word.
- After edge 32·D+1: rx_valid=0. A start sampled at edge 32·D+1 is accepted, so back-to-back transactions have one idle cycle of ss_n high.
- Each transaction takes 32·D+1 cycles from accept to the next accept opportunity.
- start at edge 32·D is ignored because busy is still 1 before that edge.
- The device sees mode 0 timing: mosi is stable for D cycles before each sclk rise, and setup/hold is one full half-period.

## Test plan
- CLK_DIV=1, miso looped to mosi, start with tx_data=16'hA5C3 -> after 32 cycles rx_valid pulses for one cycle, rx_data=16'hA5C3, 16 sclk rises, ss_n low for exactly 32 cycles.
- CLK_DIV=3, miso tied 1, tx_data=16'h000F -> mosi shows 0000_0000_0000_1111 MSB first with each bit held 6 cycles, rx_data=16'hFFFF at cycle 96, busy low from cycle 96.
- Start pulsed again at cycles 5, 20 and 32 of a CLK_DIV=1 transfer with tx_data=16'h1234 -> ignored, exactly one rx_valid. A start at cycle 33 is accepted and ss_n is high only during cycle 33.
- rst asserted at cycle 17 of a CLK_DIV=1 transfer whose previous result was 16'h5A5A -> outputs at reset values immediately (rx_data=16'h0000), no rx_valid, and the next start completes normally.
- Device model returning 16'hC0DE MSB-first while tx_data=16'h0F00, CLK_DIV=2 -> rx_data=16'hC0DE. rx_data stays 16'hC0DE with rx_valid=0 for 100 idle cycles.

Source files
------------

// File: rtl/spi_word_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_word_master
// Brief    : Single-word (16-bit) SPI mode-0 master, MSB first, with a
//            start/busy/valid handshake toward the boot mailbox bank.
// Revision : 1.0 - initial release
// ============================================================================
module spi_word_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clkEth,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx_data,
  output logic        busy,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_n
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        miso_bit;
  logic        div_done;
  logic        accept;
  logic        last_bit;

  assign div_done = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == 4'd15);
  // DONE already reports busy=0, so a start there is taken back-to-back.
  assign accept   = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = SHIFT_LO;
      SHIFT_LO: if (div_done) state_next = SHIFT_HI;
      SHIFT_HI: if (div_done) state_next = last_bit ? DONE : SHIFT_LO;
      DONE:     state_next = accept ? SHIFT_LO : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkEth or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= 8'd0;
      bit_cnt  <= 4'd0;
      shreg    <= 16'h0000;
      miso_bit <= 1'b0;
      rx_data  <= 16'h0000;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            shreg   <= tx_data;
            div_cnt <= 8'd0;
            bit_cnt <= 4'd0;
          end
        end
        SHIFT_LO: begin
          if (div_done) begin
            div_cnt  <= 8'd0;
            miso_bit <= miso;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_done) begin
            div_cnt <= 8'd0;
            shreg   <= {shreg[14:0], miso_bit};
            bit_cnt <= bit_cnt + 4'd1;
            if (last_bit) rx_data <= {shreg[14:0], miso_bit};
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == SHIFT_LO) || (state == SHIFT_HI);
  assign ss_n     = !busy;
  assign sclk     = (state == SHIFT_HI);
  assign mosi     = busy && shreg[15];
  assign rx_valid = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_spi_word_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_word_master
// Brief    : Self-checking bench for spi_word_master at CLK_DIV = 1, 2 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_word_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v    [3];
  logic [15:0] tx_v       [3];
  logic        busy_v     [3];
  logic [15:0] rx_data_v  [3];
  logic        rx_valid_v [3];
  logic        sclk_v     [3];
  logic        mosi_v     [3];
  logic        miso_v     [3];
  logic        ss_n_v     [3];
  logic        miso_drv   [3];
  logic        loop_v     [3];

  int checks = 0;
  int fails  = 0;

  logic [4:0]  obs [0:127];   // {busy, ss_n, sclk, mosi, rx_valid} after each edge
  logic [15:0] obs_rx;

  always #5 clk = ~clk;

  assign miso_v[0] = loop_v[0] ? mosi_v[0] : miso_drv[0];
  assign miso_v[1] = loop_v[1] ? mosi_v[1] : miso_drv[1];
  assign miso_v[2] = loop_v[2] ? mosi_v[2] : miso_drv[2];

  spi_word_master #(.CLK_DIV(1)) u_div1 (
    .clkEth(clk), .rst(rst), .start(start_v[0]), .tx_data(tx_v[0]),
    .busy(busy_v[0]), .rx_data(rx_data_v[0]), .rx_valid(rx_valid_v[0]),
    .sclk(sclk_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]), .ss_n(ss_n_v[0]));

  spi_word_master #(.CLK_DIV(2)) u_div2 (
    .clkEth(clk), .rst(rst), .start(start_v[1]), .tx_data(tx_v[1]),
    .busy(busy_v[1]), .rx_data(rx_data_v[1]), .rx_valid(rx_valid_v[1]),
    .sclk(sclk_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]), .ss_n(ss_n_v[1]));

  spi_word_master #(.CLK_DIV(3)) u_div3 (
    .clkEth(clk), .rst(rst), .start(start_v[2]), .tx_data(tx_v[2]),
    .busy(busy_v[2]), .rx_data(rx_data_v[2]), .rx_valid(rx_valid_v[2]),
    .sclk(sclk_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2]), .ss_n(ss_n_v[2]));

  // Expected pin pattern k edges after the accepting edge, from the timing rules.
  function automatic logic [4:0] model_sig(input int d, input logic [15:0] tx, input int k,
                                           input bit restart, input logic [15:0] tx2);
    int f;
    if (k < 32 * d) begin
      f = k / (2 * d);
      return {1'b1, 1'b0, ((k / d) % 2) == 1, tx[15 - f], 1'b0};
    end
    if (k == 32 * d) return 5'b01001;
    return restart ? {1'b1, 1'b0, 1'b0, tx2[15], 1'b0} : 5'b01000;
  endfunction

  // Drives one transaction on instance s and records the pins after every edge.
  task automatic xfer(input int s, input logic [15:0] tx, input logic [15:0] dev,
                      input bit pre_started, input logic [127:0] pulses,
                      input logic [15:0] pulse_tx);
    int d;
    d = s + 1;
    if (!pre_started) begin
      tx_v[s]    = tx;
      start_v[s] = 1'b1;
      @(posedge clk); #1;
    end
    start_v[s] = 1'b0;
    tx_v[s]    = 16'($urandom);
    for (int k = 0; k <= 32 * d + 1; k++) begin
      obs[k] = {busy_v[s], ss_n_v[s], sclk_v[s], mosi_v[s], rx_valid_v[s]};
      if (k == 32 * d) obs_rx = rx_data_v[s];
      if (k == 32 * d + 1) break;
      miso_drv[s] = (k < 32 * d) ? dev[15 - k / (2 * d)] : 1'b0;
      start_v[s]  = pulses[k + 1];
      tx_v[s]     = pulses[k + 1] ? pulse_tx : 16'($urandom);
      @(posedge clk); #1;
    end
    start_v[s] = 1'b0;
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if ({busy_v[s], ss_n_v[s], sclk_v[s], mosi_v[s], rx_valid_v[s], rx_data_v[s]}
          !== {5'b01000, 16'h0000}) begin
        fails++;
        $display("FAIL reset_state[%0d]: got %b_%h expected 01000_0000", s,
                 {busy_v[s], ss_n_v[s], sclk_v[s], mosi_v[s], rx_valid_v[s]}, rx_data_v[s]);
      end
    end
  endtask

  task automatic test_loopback;
    logic [15:0] w;
    int rises, low;
    loop_v[0] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      w = (t == 0) ? 16'hA5C3 : 16'($urandom);
      xfer(0, w, 16'h0000, 1'b0, '0, 16'h0000);
      for (int k = 0; k <= 33; k++) begin
        checks++;
        if (obs[k] !== model_sig(1, w, k, 1'b0, 16'h0)) begin
          fails++;
          $display("FAIL loopback_pins w=%h k=%0d: got %b expected %b", w, k, obs[k],
                   model_sig(1, w, k, 1'b0, 16'h0));
        end
      end
      checks++;
      if (obs_rx !== w) begin
        fails++;
        $display("FAIL loopback_rx: got %h expected %h", obs_rx, w);
      end
      rises = 0;
      low   = 0;
      for (int k = 0; k <= 33; k++) begin
        if (obs[k][2] && (k == 0 || !obs[k - 1][2])) rises++;
        if (!obs[k][3]) low++;
      end
      checks++;
      if (rises !== 16 || low !== 32) begin
        fails++;
        $display("FAIL loopback_counts: got rises=%0d ss_low=%0d expected 16 and 32", rises, low);
      end
    end
    loop_v[0] = 1'b0;
  endtask

  task automatic test_miso_high;
    xfer(2, 16'h000F, 16'hFFFF, 1'b0, '0, 16'h0000);
    for (int k = 0; k <= 97; k++) begin
      checks++;
      if (obs[k] !== model_sig(3, 16'h000F, k, 1'b0, 16'h0)) begin
        fails++;
        $display("FAIL div3_pins k=%0d: got %b expected %b", k, obs[k],
                 model_sig(3, 16'h000F, k, 1'b0, 16'h0));
      end
    end
    checks++;
    if (obs_rx !== 16'hFFFF) begin
      fails++;
      $display("FAIL div3_rx: got %h expected ffff", obs_rx);
    end
  endtask

  task automatic test_device;
    logic [15:0] tx, dev;
    for (int t = 0; t < 4; t++) begin
      tx  = (t == 0) ? 16'h0F00 : 16'($urandom);
      dev = (t == 0) ? 16'hC0DE : 16'($urandom);
      xfer(1, tx, dev, 1'b0, '0, 16'h0000);
      for (int k = 0; k <= 65; k++) begin
        checks++;
        if (obs[k] !== model_sig(2, tx, k, 1'b0, 16'h0)) begin
          fails++;
          $display("FAIL device_pins tx=%h k=%0d: got %b expected %b", tx, k, obs[k],
                   model_sig(2, tx, k, 1'b0, 16'h0));
        end
      end
      checks++;
      if (obs_rx !== dev) begin
        fails++;
        $display("FAIL device_rx: got %h expected %h", obs_rx, dev);
      end
      if (t == 0) begin
        for (int c = 0; c < 100; c++) begin
          @(posedge clk); #1;
          checks++;
          if ({rx_valid_v[1], rx_data_v[1]} !== {1'b0, 16'hC0DE}) begin
            fails++;
            $display("FAIL device_hold c=%0d: got valid=%b rx=%h expected 0 c0de", c,
                     rx_valid_v[1], rx_data_v[1]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] pulses;
    int valids;
    pulses     = '0;
    pulses[5]  = 1'b1;
    pulses[20] = 1'b1;
    pulses[32] = 1'b1;
    pulses[33] = 1'b1;
    loop_v[0]  = 1'b1;
    xfer(0, 16'h1234, 16'h0000, 1'b0, pulses, 16'hBEEF);
    valids = 0;
    for (int k = 0; k <= 33; k++) begin
      if (obs[k][0]) valids++;
      checks++;
      if (obs[k] !== model_sig(1, 16'h1234, k, 1'b1, 16'hBEEF)) begin
        fails++;
        $display("FAIL b2b_first_pins k=%0d: got %b expected %b", k, obs[k],
                 model_sig(1, 16'h1234, k, 1'b1, 16'hBEEF));
      end
    end
    checks++;
    if (obs_rx !== 16'h1234 || valids !== 1) begin
      fails++;
      $display("FAIL b2b_first_rx: got %h valids=%0d expected 1234 valids=1", obs_rx, valids);
    end
    xfer(0, 16'hBEEF, 16'h0000, 1'b1, '0, 16'h0000);
    for (int k = 0; k <= 33; k++) begin
      checks++;
      if (obs[k] !== model_sig(1, 16'hBEEF, k, 1'b0, 16'h0)) begin
        fails++;
        $display("FAIL b2b_second_pins k=%0d: got %b expected %b", k, obs[k],
                 model_sig(1, 16'hBEEF, k, 1'b0, 16'h0));
      end
    end
    checks++;
    if (obs_rx !== 16'hBEEF) begin
      fails++;
      $display("FAIL b2b_second_rx: got %h expected beef", obs_rx);
    end
    loop_v[0] = 1'b0;
  endtask

  task automatic test_reset_midxfer;
    logic [15:0] w;
    loop_v[0] = 1'b1;
    xfer(0, 16'h5A5A, 16'h0000, 1'b0, '0, 16'h0000);
    checks++;
    if (obs_rx !== 16'h5A5A) begin
      fails++;
      $display("FAIL abort_prev_rx: got %h expected 5a5a", obs_rx);
    end
    tx_v[0]    = 16'($urandom);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy_v[0], ss_n_v[0], sclk_v[0], mosi_v[0], rx_valid_v[0], rx_data_v[0]}
        !== {5'b01000, 16'h0000}) begin
      fails++;
      $display("FAIL abort_immediate: got %b_%h expected 01000_0000",
               {busy_v[0], ss_n_v[0], sclk_v[0], mosi_v[0], rx_valid_v[0]}, rx_data_v[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst = 1'b0;
      checks++;
      if ({busy_v[0], ss_n_v[0], rx_valid_v[0], rx_data_v[0]} !== {3'b010, 16'h0000}) begin
        fails++;
        $display("FAIL abort_hold c=%0d: got %b_%h expected 010_0000", c,
                 {busy_v[0], ss_n_v[0], rx_valid_v[0]}, rx_data_v[0]);
      end
    end
    w = 16'($urandom);
    xfer(0, w, 16'h0000, 1'b0, '0, 16'h0000);
    for (int k = 0; k <= 33; k++) begin
      checks++;
      if (obs[k] !== model_sig(1, w, k, 1'b0, 16'h0)) begin
        fails++;
        $display("FAIL abort_next_pins k=%0d: got %b expected %b", k, obs[k],
                 model_sig(1, w, k, 1'b0, 16'h0));
      end
    end
    checks++;
    if (obs_rx !== w) begin
      fails++;
      $display("FAIL abort_next_rx: got %h expected %h", obs_rx, w);
    end
    loop_v[0] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      start_v[s]  = 1'b0;
      tx_v[s]     = 16'h0000;
      miso_drv[s] = 1'b0;
      loop_v[s]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_loopback;
    test_miso_high;
    test_device;
    test_back_to_back;
    test_reset_midxfer;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
